// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops 64-bit words from the read side of a clock-crossing
// FIFO, validates a one-word header (magic + beat count) and streams the
// payload as 32-bit beats (low half first) on a valid/ready/last interface.
// Rejected headers are dropped, flagged for one cycle and counted.
module fifo_frame_reader #(
  parameter logic [15:0] MAGIC   = 16'hC0DE,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        i_rd_clk,
  input  logic        i_rst,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_en,
  input  logic [63:0] i_fifo_dout,
  output logic [31:0] o_m_data,
  output logic        o_m_valid,
  input  logic        i_m_ready,
  output logic        o_m_last,
  output logic [15:0] o_frame_len,
  output logic        o_busy,
  output logic        o_hdr_error,
  output logic [15:0] o_err_count
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LEN_W   = 16;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_HDR     = 3'd1;
  localparam logic [STATE_W-1:0] S_FETCH   = 3'd2;
  localparam logic [STATE_W-1:0] S_LOAD    = 3'd3;
  localparam logic [STATE_W-1:0] S_EMIT_LO = 3'd4;
  localparam logic [STATE_W-1:0] S_EMIT_HI = 3'd5;

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ERR_SAT   = 16'hFFFF;

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic [31:0]        r_buf_hi, w_buf_hi_nxt;
  logic [LEN_W-1:0]   r_remaining, w_remaining_nxt;
  logic [31:0]        r_m_data, w_m_data_nxt;
  logic               r_m_valid, w_m_valid_nxt;
  logic               r_m_last, w_m_last_nxt;
  logic [LEN_W-1:0]   r_frame_len, w_frame_len_nxt;
  logic [LEN_W-1:0]   r_err_count, w_err_count_nxt;
  logic               w_rd_en;
  logic               w_hdr_error;
  logic               w_handshake;
  logic [LEN_W-1:0]   w_hdr_len;
  logic               w_hdr_ok;

  assign w_hdr_len   = i_fifo_dout[15:0];
  assign w_hdr_ok    = (i_fifo_dout[63:48] == MAGIC) &&
                       (w_hdr_len != '0) && (w_hdr_len <= MAX_LEN_W);
  assign w_handshake = r_m_valid && i_m_ready;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge i_rd_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_buf_hi    <= '0;
      r_remaining <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_frame_len <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf_hi    <= w_buf_hi_nxt;
      r_remaining <= w_remaining_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_last    <= w_m_last_nxt;
      r_frame_len <= w_frame_len_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  // Next-state, pop request and next register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_buf_hi_nxt    = r_buf_hi;
    w_remaining_nxt = r_remaining;
    w_m_data_nxt    = r_m_data;
    w_m_valid_nxt   = r_m_valid;
    w_m_last_nxt    = r_m_last;
    w_frame_len_nxt = r_frame_len;
    w_err_count_nxt = r_err_count;
    w_rd_en         = 1'b0;
    w_hdr_error     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!i_fifo_empty) begin
          w_rd_en     = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (w_hdr_ok) begin
          w_frame_len_nxt = w_hdr_len;
          w_remaining_nxt = w_hdr_len;
          w_state_nxt     = S_FETCH;
        end else begin
          w_hdr_error = 1'b1;
          if (r_err_count != ERR_SAT) begin
            w_err_count_nxt = r_err_count + LEN_W'(1);
          end
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (!i_fifo_empty) begin
          w_rd_en     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_buf_hi_nxt  = i_fifo_dout[63:32];
        w_m_data_nxt  = i_fifo_dout[31:0];
        w_m_valid_nxt = 1'b1;
        w_m_last_nxt  = (r_remaining == LEN_W'(1));
        w_state_nxt   = S_EMIT_LO;
      end
      S_EMIT_LO: begin
        if (w_handshake) begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            w_m_valid_nxt = 1'b0;
            w_m_last_nxt  = 1'b0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_m_data_nxt = r_buf_hi;
            w_m_last_nxt = (r_remaining == LEN_W'(2));
            w_state_nxt  = S_EMIT_HI;
          end
        end
      end
      S_EMIT_HI: begin
        if (w_handshake) begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          w_m_valid_nxt   = 1'b0;
          w_m_last_nxt    = 1'b0;
          w_state_nxt     = (r_remaining == LEN_W'(1)) ? S_IDLE : S_FETCH;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_m_valid_nxt = 1'b0;
        w_m_last_nxt  = 1'b0;
      end
    endcase
  end

  // Pop is suppressed while in reset so the FIFO sees no request during its own clear.
  assign o_fifo_rd_en = w_rd_en && !i_rst;
  assign o_hdr_error  = w_hdr_error && !i_rst;
  assign o_busy       = (r_state != S_IDLE);
  assign o_m_data     = r_m_data;
  assign o_m_valid    = r_m_valid;
  assign o_m_last     = r_m_last;
  assign o_frame_len  = r_frame_len;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Testbench for fifo_frame_reader: queue-based FIFO model, frame-level
// scoreboard of expected beats, per-cycle protocol checks and directed scenarios.
module tb_fifo_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [63:0] fifo_dout;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] frame_len;
  logic        busy;
  logic        hdr_error;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  fifo_frame_reader dut (
    .i_rd_clk    (clk),
    .i_rst       (rst),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd_en(fifo_rd_en),
    .i_fifo_dout (fifo_dout),
    .o_m_data    (m_data),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_m_last    (m_last),
    .o_frame_len (frame_len),
    .o_busy      (busy),
    .o_hdr_error (hdr_error),
    .o_err_count (err_count)
  );

  logic [63:0] fq[$];        // words visible in the FIFO
  logic [63:0] pend[$];      // words held back to create an underrun
  logic [32:0] exp_q[$];     // expected beats {last, data}
  logic [31:0] beats[$];     // payload for the next push_frame
  logic [31:0] log_data[$];
  logic        log_last[$];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;
  int hdr_pulses = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int lat_armed = 0;
  int lat_pop = -1;
  int lat_valid = -1;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // FIFO read port: pop on the edge where rd_en is high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
  end

  // Empty flag refreshed once per cycle, well away from the rising edge.
  always @(negedge clk) begin
    #1;
    fifo_empty = (fq.size() == 0);
  end

  // Sink ready: held high or coin-flipped each cycle.
  always @(posedge clk) begin
    #1;
    if (rdy_mode != 0) m_ready = 1'($urandom_range(0, 1));
    else m_ready = 1'b1;
  end

  // Per-cycle compare against the scoreboard, sampled just before the rising edge.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty) check("rd_en_while_empty", 1, 0);
      if (prev_valid && !prev_ready) begin
        check("stall_valid", 64'(m_valid), 1);
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (hdr_error) hdr_pulses++;
      if (lat_armed != 0 && lat_pop < 0 && fifo_rd_en) lat_pop = cyc;
      if (lat_armed != 0 && lat_valid < 0 && m_valid) lat_valid = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("beat_data", 64'(m_data), 64'(e[31:0]));
          check("beat_last", 64'(m_last), 64'(e[32]));
        end
        log_data.push_back(m_data);
        log_last.push_back(m_last);
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Push a header plus payload from `beats`; the model decides acceptance from the header alone.
  task automatic push_frame(input logic [63:0] hdr, input int now_words);
    int n;
    int words;
    logic [31:0] lo;
    logic [31:0] hi;
    n = int'(hdr[15:0]);
    fq.push_back(hdr);
    if (hdr[63:48] != 16'hC0DE || n < 1 || n > 1024) begin
      exp_err++;
      return;
    end
    words = (n + 1) / 2;
    for (int k = 0; k < words; k++) begin
      lo = beats[2*k];
      hi = (2*k + 1 < n) ? beats[2*k+1] : 32'hDEAD_BEEF;
      if (k < now_words) fq.push_back({hi, lo});
      else pend.push_back({hi, lo});
    end
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), beats[i]});
  endtask

  task automatic set_beats(input logic [31:0] base, input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(base + 32'(i));
  endtask

  task automatic wait_done(input string name);
    int done;
    done = 0;
    for (int i = 0; i < 400 && done == 0; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && fq.size() == 0 && pend.size() == 0 && !busy) done = 1;
    end
    check(name, 64'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(m_valid), 0);
    check({tag, "_last"}, 64'(m_last), 0);
    check({tag, "_data"}, 64'(m_data), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_rd_en"}, 64'(fifo_rd_en), 0);
    check({tag, "_hdr_err"}, 64'(hdr_error), 0);
    check({tag, "_frame_len"}, 64'(frame_len), 0);
    check({tag, "_err_count"}, 64'(err_count), 0);
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout = '0;
    #1;
    check_reset_outputs("rst_init");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_rst");

    // Frame of 4 beats, ready held high, latency pinned.
    log_data.delete(); log_last.delete();
    beats.delete();
    beats.push_back(32'h1111_1111); beats.push_back(32'h2222_2222);
    beats.push_back(32'h3333_3333); beats.push_back(32'h4444_4444);
    lat_pop = -1; lat_valid = -1; lat_armed = 1;
    push_frame(64'hC0DE_0000_0000_0004, 2);
    wait_done("t1_done");
    lat_armed = 0;
    check("t1_latency", 64'(lat_valid - lat_pop), 4);
    check("t1_count", 64'(log_data.size()), 4);
    if (log_data.size() == 4) begin
      check("t1_b0", 64'(log_data[0]), 64'h1111_1111);
      check("t1_b1", 64'(log_data[1]), 64'h2222_2222);
      check("t1_b2", 64'(log_data[2]), 64'h3333_3333);
      check("t1_b3", 64'(log_data[3]), 64'h4444_4444);
      check("t1_lastmask", 64'({log_last[3], log_last[2], log_last[1], log_last[0]}), 64'h8);
    end
    check("t1_frame_len", 64'(frame_len), 4);

    // Odd length then a following frame.
    log_data.delete(); log_last.delete();
    set_beats(32'hA000_0001, 3);
    push_frame(64'hC0DE_1234_5678_0003, 2);
    set_beats(32'hB000_0010, 2);
    push_frame(64'hC0DE_0000_0000_0002, 1);
    wait_done("t2_done");
    check("t2_count", 64'(log_data.size()), 5);
    if (log_data.size() == 5) begin
      check("t2_b2", 64'(log_data[2]), 64'hA000_0003);
      check("t2_last2", 64'(log_last[2]), 1);
      check("t2_b3", 64'(log_data[3]), 64'hB000_0010);
    end
    check("t2_frame_len", 64'(frame_len), 2);

    // Three malformed headers, then a good frame.
    log_data.delete(); log_last.delete();
    push_frame(64'hBEEF_0000_0000_0002, 0);
    push_frame(64'hC0DE_0000_0000_0000, 0);
    push_frame(64'hC0DE_0000_0000_0401, 0);
    set_beats(32'hC000_0100, 2);
    push_frame(64'hC0DE_0000_0000_0002, 1);
    wait_done("t3_done");
    check("t3_err_count", 64'(err_count), 3);
    check("t3_pulses", 64'(hdr_pulses), 3);
    check("t3_count", 64'(log_data.size()), 2);

    // Random backpressure on an 8-beat frame.
    rdy_mode = 1;
    set_beats(32'hD000_0200, 8);
    push_frame(64'hC0DE_0000_0000_0008, 4);
    wait_done("t4_done");
    rdy_mode = 0;
    @(posedge clk); #1;
    check("t4_frame_len", 64'(frame_len), 8);

    // Underrun between payload words: must wait in FETCH without valid.
    set_beats(32'hE000_0300, 4);
    push_frame(64'hC0DE_0000_0000_0004, 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
        @(posedge clk); #1;
        if (exp_q.size() == 2) seen = 1;
      end
      check("t5_reach_gap", 64'(seen), 1);
    end
    for (int i = 0; i < 5; i++) begin
      check("t5_gap_state", 64'({m_valid, busy, fifo_rd_en}), 64'(3'b010));
      @(posedge clk); #1;
    end
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    wait_done("t5_done");

    // Reset asserted in the middle of a 6-beat frame, during the high-half beat.
    set_beats(32'hF000_0400, 6);
    push_frame(64'hC0DE_0000_0000_0006, 3);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
        @(posedge clk); #1;
        if (exp_q.size() == 5) seen = 1;
      end
      check("t6_reach_hi", 64'(seen), 1);
    end
    check("t6_hi_data", 64'(m_data), 64'hF000_0401);
    #2 rst = 1'b1;
    fq.delete(); pend.delete(); exp_q.delete();
    exp_err = 0;
    #1;
    hdr_pulses = 0;
    check_reset_outputs("t6_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    log_data.delete(); log_last.delete();
    set_beats(32'h5000_0500, 2);
    push_frame(64'hC0DE_0000_0000_0002, 1);
    wait_done("t6_done");
    check("t6_count", 64'(log_data.size()), 2);
    if (log_data.size() == 2) check("t6_lastmask", 64'({log_last[1], log_last[0]}), 64'h2);
    check("t6_frame_len", 64'(frame_len), 2);

    check("final_err_count", 64'(err_count), 64'(exp_err));
    check("final_pulses", 64'(hdr_pulses), 64'(exp_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
